// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-rate divider, h/v counters, registered syncs and visible-window flag.
// Latency: sync/bright are registered from the next counter values, so they line up with hCount/vCount.
// Backpressure: none; the block free-runs after reset.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pixel_tick,
    output logic       frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BACK + V_VISIBLE);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          bright_q, bright_d;
    logic          tick_q, tick_d;
    logic          fstart_q, fstart_d;
    logic          adv;

    always_comb begin
        adv      = (div_q == DIV_LAST);
        div_d    = adv ? '0 : div_q + DIV_ONE;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        tick_d   = adv;
        fstart_d = 1'b0;
        if (adv) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d  = '0;
                    fstart_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
        // Derived from the next counts so renderers see syncs/bright aligned with the counters.
        hsync_d  = (h_cnt_d >= H_SYNC_W);
        vsync_d  = (v_cnt_d >= V_SYNC_W);
        bright_d = (h_cnt_d >= H_VIS_LO) && (h_cnt_d < H_VIS_HI) &&
                   (v_cnt_d >= V_VIS_LO) && (v_cnt_d < V_VIS_HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
            tick_q   <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
            tick_q   <= tick_d;
            fstart_q <= fstart_d;
        end
    end

    assign hCount      = h_cnt_q;
    assign vCount      = v_cnt_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign bright      = bright_q;
    assign pixel_tick  = tick_q;
    assign frame_start = fstart_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the 640x480 @ 60 Hz VGA display path.
- Divides the board clock down to the pixel rate and runs horizontal and vertical pixel counters.
- Produces the sync pulses and drives bright, hCount and vCount directly into the screen renderers (title, game, done screens).
- Renderers are purely combinational on hCount, vCount and bright; this block is their only sequential timing source.

Parameters:
- CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
- H_SYNC, 96, horizontal sync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- V_SYNC, 2, vertical sync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.

Ports:
- clk, input, 1, board clock; sole clock.
- reset, input, 1, asynchronous active-high reset.
- hCount, output, 10, horizontal pixel counter, 0..H_TOTAL-1.
- vCount, output, 10, vertical line counter, 0..V_TOTAL-1.
- hSync, output, 1, horizontal sync, active-low.
- vSync, output, 1, vertical sync, active-low.
- bright, output, 1, high while the current pixel is in the visible window.
- pixel_tick, output, 1, one-clk pulse marking each counter advance.
- frame_start, output, 1, one-clk pulse when the counters wrap to (0,0).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Port names are clk and reset.
- Derived constants: H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT (800); V_TOTAL = V_SYNC+V_BACK+V_VISIBLE+V_FRONT (525).
- Counter ordering is sync, back porch, visible, front porch.
- Visible window: hCount in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] = [144, 783], and vCount in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1] = [35, 514].
- Reset values, applied asynchronously while reset=1:
  - divider = 0, hCount = 0, vCount = 0.
  - hSync = 0 and vSync = 0, because count 0 is inside the sync pulse.
  - bright = 0, pixel_tick = 0, frame_start = 0.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and is 1 for exactly the clk cycle after the divider reads CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is 1 on every cycle after reset deasserts.
- Advance rule: on each clk edge where the divider reads CLK_DIV-1:
  - If hCount == H_TOTAL-1: hCount <= 0, and vCount <= (vCount == V_TOTAL-1) ? 0 : vCount+1.
  - Otherwise hCount <= hCount+1 and vCount holds.
  - Counters never leave range. Arithmetic is 10-bit unsigned; every default total fits in 10 bits.
- Derived outputs:
  - hSync, vSync and bright are registered.
  - They are computed from the next counter values, so in every cycle they are consistent with the hCount and vCount presented in that same cycle (zero-cycle skew for the renderers).
  - hSync = ~(hCount < H_SYNC); vSync = ~(vCount < V_SYNC); bright = hVisible & vVisible.
  - All outputs change only on advancing edges, or on reset.
- frame_start is 1 for the single clk cycle in which hCount and vCount have just become (0,0) through wrap. It is not asserted on reset release.
- Reset mid-frame: all state returns to reset values immediately. After release, the first advance happens CLK_DIV clocks later and takes hCount from 0 to 1.
- No other inputs; the block free-runs after reset.

Test Plan:
- Reset release, CLK_DIV=4 -> pixel_tick pulses at clocks 4, 8, 12, ...; hCount reads 1 after clock 4 and 2 after clock 8; hSync=0 and bright=0 throughout.
- Run one full line -> hSync rises when hCount becomes 96; bright rises at hCount=144 only once vCount>=35; hCount wraps 799->0 and vCount increments on that same edge.
- Run one full frame -> vSync=0 for vCount 0..1 and 1 from vCount 2 onward; bright=1 for exactly 640x480 = 307200 pixel ticks; frame_start pulses once, 800x525x4 = 1,680,000 clocks after the previous wrap.
- Corner (hCount=799, vCount=524) -> next advance gives (0,0), frame_start=1 for one clk, hSync=0, vSync=0.
- Assert reset at (hCount=400, vCount=200) for 3 clocks -> all outputs immediately at reset values; after release, restart from (0,0) with the first tick 4 clocks later.
- CLK_DIV=1 build -> pixel_tick constantly 1 after reset; full line takes exactly 800 clocks.
